// File: rtl/signal_cross_pkg.sv
// -----------------------------------------------------------------------------
// signal_cross_pkg -- shared fpu package for the crossover signal block.
//
// Provides:
//   FP_W        float width (IEEE-754 single)
//   FP_NAN_EXP  all-ones exponent that marks Inf/NaN
//   state_e     trend state encoding, which is also the trend output encoding
//   is_nan()    NaN test: exponent all ones, mantissa nonzero
// -----------------------------------------------------------------------------
package signal_cross_pkg;

  localparam int         FP_W       = 32;
  localparam int         FP_EXP_W   = 8;
  localparam int         FP_MAN_W   = 23;
  localparam logic [7:0] FP_NAN_EXP = 8'hFF;

  typedef enum logic [1:0] {
    ST_UNPRIMED = 2'b00,
    ST_ABOVE    = 2'b01,
    ST_BELOW    = 2'b10
  } state_e;

  function automatic logic is_nan(input logic [FP_W-1:0] f);
    return (f[FP_W-2 -: FP_EXP_W] == FP_NAN_EXP) && (f[FP_MAN_W-1:0] != '0);
  endfunction

endpackage

// File: rtl/signal_cross_fp_gt.sv
// -----------------------------------------------------------------------------
// fp_gt -- combinational IEEE-754 single "greater than" (f1 > f2).
//
// Ports:
//   f1  input  [31:0]  left operand
//   f2  input  [31:0]  right operand
//   gt  output         1 when f1 > f2
//
// NaN operands are screened out by the caller. +0 and -0 compare equal, so
// neither is greater than the other. Inf orders naturally through the
// sign-magnitude rule.
// -----------------------------------------------------------------------------
module fp_gt
  import signal_cross_pkg::*;
(
  input  logic [FP_W-1:0] f1,
  input  logic [FP_W-1:0] f2,
  output logic            gt
);

  logic              s1, s2;
  logic [FP_W-2:0]   m1, m2;
  logic              both_zero;

  assign s1 = f1[FP_W-1];
  assign s2 = f2[FP_W-1];
  assign m1 = f1[FP_W-2:0];
  assign m2 = f2[FP_W-2:0];
  assign both_zero = (m1 == '0) && (m2 == '0);

  // Sign-magnitude ordering: for two negatives the larger magnitude is the
  // smaller value.
  always_comb begin
    if (both_zero)       gt = 1'b0;
    else if (s1 != s2)   gt = s2;
    else if (!s1)        gt = (m1 > m2);
    else                 gt = (m1 < m2);
  end

endmodule

// File: rtl/signal_cross.sv
// -----------------------------------------------------------------------------
// signal_cross -- fast/slow indicator crossover detector.
//
// Each accepted sample (in_valid && in_ready) is classified as IGNORE (NaN on
// either input), HOLD (bitwise equal) or GT/LT via fp_gt. A three-state FSM
// (UNPRIMED/ABOVE/BELOW) tracks the relation; BELOW->ABOVE raises a buy event,
// ABOVE->BELOW a sell event. Events are registered (latency 1) and held until
// the consumer takes them.
//
// Parameters:
//   COOLDOWN  samples for which events are suppressed after an event (1..255);
//             used only when SIGNAL_CROSS_COOLDOWN_EN is defined.
// Ports:
//   clk        input        clock, rising edge
//   rst_n      input        asynchronous active-low reset
//   in_valid   input        sample present on fast/slow
//   in_ready   output       sample can be accepted this cycle
//   fast       input  [31]  fast indicator (IEEE-754 single)
//   slow       input  [31]  slow indicator (IEEE-754 single)
//   sig_valid  output       event pending
//   sig_ready  input        consumer takes the event this cycle
//   sig_buy    output       pending event is a buy
//   sig_sell   output       pending event is a sell
//   trend      output [1:0] 00 UNPRIMED, 01 ABOVE, 10 BELOW
//
// Configuration macro: SIGNAL_CROSS_COOLDOWN_EN enables the event cooldown
// counter; without it every crossing is emitted.
// -----------------------------------------------------------------------------
module signal_cross
  import signal_cross_pkg::*;
#(
  parameter int COOLDOWN = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [FP_W-1:0] fast,
  input  logic [FP_W-1:0] slow,
  output logic            sig_valid,
  input  logic            sig_ready,
  output logic            sig_buy,
  output logic            sig_sell,
  output logic [1:0]      trend
);

  if (COOLDOWN < 1 || COOLDOWN > 255) begin : g_bad_cooldown
    $error("signal_cross: COOLDOWN must be in 1..255");
  end

  state_e state_q, state_d;
  logic   sig_valid_q, sig_valid_d;
  logic   sig_buy_q, sig_buy_d;
  logic   sig_sell_q, sig_sell_d;

  logic   gt;
  logic   accept;
  logic   classify;
  logic   cross_buy, cross_sell;
  logic   fire;

  fp_gt u_fp_gt (
    .f1 (fast),
    .f2 (slow),
    .gt (gt)
  );

  // A pending event blocks new samples unless it is consumed this cycle, so
  // an event can never be overwritten before it is seen.
  assign in_ready = !sig_valid_q || sig_ready;
  assign accept   = in_valid && in_ready;
  assign classify = accept && !is_nan(fast) && !is_nan(slow) && (fast != slow);

  // NOTE: every signal driven here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cross_buy  = 1'b0;
    cross_sell = 1'b0;
    if (classify) begin
      unique case (state_q)
        ST_UNPRIMED: state_d = gt ? ST_ABOVE : ST_BELOW;
        ST_ABOVE: if (!gt) begin
          state_d    = ST_BELOW;
          cross_sell = 1'b1;
        end
        ST_BELOW: if (gt) begin
          state_d   = ST_ABOVE;
          cross_buy = 1'b1;
        end
        default: state_d = ST_UNPRIMED;
      endcase
    end
  end

`ifdef SIGNAL_CROSS_COOLDOWN_EN
  logic [7:0] cd_cnt_q, cd_cnt_d;

  // The counter value seen at acceptance decides suppression; the state
  // transition happens regardless.
  always_comb begin
    fire     = (cross_buy || cross_sell) && (cd_cnt_q == 8'd0);
    cd_cnt_d = cd_cnt_q;
    if (fire)                           cd_cnt_d = 8'(COOLDOWN);
    else if (accept && cd_cnt_q != 8'd0) cd_cnt_d = cd_cnt_q - 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cd_cnt_q <= 8'd0;
    else        cd_cnt_q <= cd_cnt_d;
  end
`else
  assign fire = cross_buy || cross_sell;
`endif

  // A new event wins over clearing: a handshake edge that also produces an
  // event reloads the output register instead of emptying it.
  always_comb begin
    sig_valid_d = sig_valid_q;
    sig_buy_d   = sig_buy_q;
    sig_sell_d  = sig_sell_q;
    if (fire) begin
      sig_valid_d = 1'b1;
      sig_buy_d   = cross_buy;
      sig_sell_d  = cross_sell;
    end else if (sig_valid_q && sig_ready) begin
      sig_valid_d = 1'b0;
      sig_buy_d   = 1'b0;
      sig_sell_d  = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_UNPRIMED;
      sig_valid_q <= 1'b0;
      sig_buy_q   <= 1'b0;
      sig_sell_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sig_valid_q <= sig_valid_d;
      sig_buy_q   <= sig_buy_d;
      sig_sell_q  <= sig_sell_d;
    end
  end

  assign sig_valid = sig_valid_q;
  assign sig_buy   = sig_buy_q;
  assign sig_sell  = sig_sell_q;
  assign trend     = state_q;

endmodule

// File: tb/tb_signal_cross.sv
// -----------------------------------------------------------------------------
// tb_signal_cross -- self-checking bench for signal_cross.
//
// The driver keeps a behavioural model (float values decoded to real numbers,
// relation tracked as above/below, pending flag, cooldown count) and pushes
// each expected event into a queue; a monitor on the falling edge compares
// the DUT's event outputs against the queue head and pops on handshake.
// -----------------------------------------------------------------------------
module tb_signal_cross;

  localparam int CD = 2;
`ifdef SIGNAL_CROSS_COOLDOWN_EN
  localparam bit CD_EN = 1'b1;
`else
  localparam bit CD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] fast, slow;
  logic        sig_valid, sig_ready, sig_buy, sig_sell;
  logic [1:0]  trend;

  signal_cross #(.COOLDOWN(CD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fast      (fast),
    .slow      (slow),
    .sig_valid (sig_valid),
    .sig_ready (sig_ready),
    .sig_buy   (sig_buy),
    .sig_sell  (sig_sell),
    .trend     (trend)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state. Trend codes: 0 unprimed, 1 fast above slow, 2 fast below.
  logic [1:0] m_trend;
  bit         m_pend;
  int         m_cnt;
  bit         mon_en;
  logic [1:0] exp_q[$];   // {buy, sell}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit f_is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic real f2r(input logic [31:0] x);
    real mag;
    int  e;
    e = int'(x[30:23]);
    if (e == 0) mag = real'(x[22:0]) * (2.0 ** (-149));
    else        mag = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** (e - 127));
    return x[31] ? -mag : mag;
  endfunction

  task automatic model_sample(input logic [31:0] f, input logic [31:0] s);
    logic [1:0] rel;
    bit         emit;
    emit = 1'b0;
    if (!f_is_nan(f) && !f_is_nan(s) && f != s) begin
      rel = (f2r(f) > f2r(s)) ? 2'd1 : 2'd2;
      if (m_trend != 2'd0 && rel != m_trend) emit = !CD_EN || (m_cnt == 0);
      if (emit) exp_q.push_back(rel == 2'd1 ? 2'b10 : 2'b01);
      m_trend = rel;
    end
    if (CD_EN) begin
      if (emit)           m_cnt = CD;
      else if (m_cnt > 0) m_cnt--;
    end
    if (emit) m_pend = 1'b1;
  endtask

  // One clock of stimulus, starting just after a rising edge.
  task automatic step(input logic v, input logic [31:0] f, input logic [31:0] s, input logic r);
    bit acc;
    in_valid  = v;
    fast      = f;
    slow      = s;
    sig_ready = r;
    #1;
    check("in_ready", in_ready, !m_pend || r);
    acc = v && (!m_pend || r);
    @(posedge clk);
    #1;
    if (m_pend && r) m_pend = 1'b0;
    if (acc) model_sample(f, s);
    check("trend", trend, m_trend);
  endtask

  task automatic model_reset();
    m_trend = 2'd0;
    m_pend  = 1'b0;
    m_cnt   = 0;
    exp_q.delete();
  endtask

  function automatic logic [31:0] rnd_val();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 11))
      0:       return {r[31], 8'hFF, r[22:0] | 23'd1};   // NaN
      1:       return 32'h0000_0000;
      2:       return 32'h8000_0000;
      3:       return 32'h7F80_0000;
      4:       return 32'hFF80_0000;
      5:       return {r[31], 8'h00, r[22:0]};            // denormal
      default: return {r[31], 8'($urandom_range(124, 130)), r[22:0]};
    endcase
  endfunction

  // Monitor: compares pending events against the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && mon_en) begin
        if (exp_q.size() == 0) begin
          check("idle_valid", 32'(sig_valid), 32'd0);
          check("idle_flags", 32'({sig_buy, sig_sell}), 32'd0);
        end else begin
          check("ev_valid", 32'(sig_valid), 32'd1);
          check("ev_kind", 32'({sig_buy, sig_sell}), 32'(exp_q[0]));
          if (sig_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] f, s;
    mon_en    = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    sig_ready = 1'b0;
    fast      = 32'd0;
    slow      = 32'd0;
    model_reset();
    #3;
    check("rst_trend", trend, 32'd0);
    check("rst_valid", 32'(sig_valid), 32'd0);
    check("rst_flags", 32'({sig_buy, sig_sell}), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Prime below, then cross above: buy.
    step(1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b1);
    check("prime_below", trend, 32'd2);
    step(1'b1, 32'h4040_0000, 32'h4000_0000, 1'b0);
    check("buy_trend", trend, 32'd1);
    check("buy_valid", 32'(sig_valid), 32'd1);
    check("buy_flag", 32'(sig_buy), 32'd1);

    // Backpressure: event held, samples refused.
    for (int i = 0; i < 10; i++) step(1'b1, 32'hBF80_0000, 32'h4000_0000, 1'b0);
    check("held_in_ready", 32'(in_ready), 32'd0);
    step(1'b0, 32'd0, 32'd0, 1'b1);
    check("released_valid", 32'(sig_valid), 32'd0);

    // NaN and equal samples in ABOVE: no change.
    step(1'b1, 32'h7FC0_0000, 32'h4000_0000, 1'b1);
    step(1'b1, 32'hBF80_0000, 32'hBF80_0000, 1'b1);
    check("nan_hold_trend", trend, 32'd1);

    // Buy then immediate sell (suppressed when cooldown is built in),
    // two more samples, then a buy crossing.
    step(1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b1);   // sell or suppressed
    step(1'b1, 32'h4040_0000, 32'h4000_0000, 1'b1);   // buy (or suppressed)
    step(1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b1);   // sell (or suppressed)
    check("cd_trend", trend, 32'd2);
    step(1'b1, 32'h4000_0000, 32'h4000_0000, 1'b1);
    step(1'b1, 32'h7FC0_0001, 32'h4000_0000, 1'b1);
    step(1'b1, 32'h4040_0000, 32'h4000_0000, 1'b1);
    check("cd_buy", 32'(sig_buy), 32'd1);

    // Asynchronous reset with an event pending.
    step(1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    step(1'b1, 32'h4040_0000, 32'h4000_0000, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_valid", 32'(sig_valid), 32'd0);
    check("arst_trend", trend, 32'd0);
    check("arst_flags", 32'({sig_buy, sig_sell}), 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 32'h4040_0000, 32'h4000_0000, 1'b1);
    check("reprime_trend", trend, 32'd1);
    check("reprime_no_event", 32'(sig_valid), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      f = rnd_val();
      s = ($urandom_range(0, 9) == 0) ? f : rnd_val();
      step(1'($urandom_range(0, 3) != 0), f, s, 1'($urandom_range(0, 9) < 7));
    end
    step(1'b0, 32'd0, 32'd0, 1'b1);
    step(1'b0, 32'd0, 32'd0, 1'b1);
    check("drain_queue", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
